full_adder_checker: RTL and testbench
=====================================

// Module: full_adder_checker
// PURPOSE
//  Self-checking exhaustive tester for the 1-bit full adder. It is the
//   response/monitor end of the adder's stimulus interface.
//  On start: drives all 8 {a,b,c_in} vectors into the adder, waits a settle
//   window per vector, samples sum/c_out, compares against the golden model.
//  Reports pass/fail, error count and first failing vector.
//  Sits on the FPGA top level beside full_adder_wrapper.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks each vector is held before sampling; legal >=1
//  ERR_CNT_W      4  width of err_count; count saturates at 2**ERR_CNT_W-1
// PORTS
//  clk         in   1          system clock; all state changes on rising edge
//  rst_n       in   1          async assert, active-low reset; one clock domain
//  start       in   1          begin run; sampled in IDLE and DONE only
//  a           out  1          DUT operand a
//  b           out  1          DUT operand b
//  c_in        out  1          DUT carry in
//  sum         in   1          DUT sum response
//  c_out       in   1          DUT carry-out response
//  busy        out  1          high in DRIVE/SAMPLE
//  done        out  1          high in DONE
//  pass        out  1          done && err_count==0
//  err_count   out  ERR_CNT_W  mismatching vectors this run (saturating)
//  fail_valid  out  1          a mismatch has been recorded this run
//  fail_vec    out  3          {a,b,c_in} of first mismatching vector
// BEHAVIOUR
//  Reset: all registered outputs 0; state IDLE; vec_idx=0; settle counter 0.
//  Vector order by vec_idx 0..7, as {a,b,c_in}:
//   000,100,010,001,110,101,011,111.
//  a/b/c_in are registered outputs; they are 0 in IDLE and DONE.
//  Golden model: exp_sum=a^b^c_in; exp_cout=(a&b)|(a&c_in)|(b&c_in).
//  FSM:
//   IDLE: start=1 -> DRIVE, vec_idx=0, clear err_count/fail_valid/fail_vec.
//   DRIVE: drive vector[vec_idx]; stay SETTLE_CYCLES clocks -> SAMPLE.
//   SAMPLE: 1 clock, vector still driven. Compare sum/c_out with golden.
//    On mismatch: err_count++ (saturate). If !fail_valid: fail_vec<=vector
//     and fail_valid<=1.
//    vec_idx==7 -> DONE; else vec_idx++ and -> DRIVE.
//   DONE: done=1 and pass valid; results held. start=1 -> DRIVE with the
//    same clearing as IDLE.
//  Latency: done rises on the 8*(SETTLE_CYCLES+1)-th rising edge after the
//   edge that accepted start (40 at default).
//  start while busy: ignored; no restart and no effect on results.
//  Results update the cycle after SAMPLE (registered compare).
//  rst_n low mid-run: immediate abort to reset values; no partial results.
//  Inputs sum/c_out are used only in SAMPLE; X/glitches in DRIVE are ignored.
// TESTING
//  1 Correct adder, SETTLE=4: pulse start -> done after 40 edges; pass=1;
//    err_count=0; fail_valid=0.
//  2 c_out stuck-at-0 -> err_count=4; fail_vec=3'b110; pass=0.
//  3 sum inverted -> err_count=8; fail_vec=3'b000. With ERR_CNT_W=2:
//    err_count=3 (saturated).
//  4 Hold start high throughout run -> single run, done at edge 40; then
//    restart from DONE clears results, second run gives same results.
//  5 rst_n low at edge 17 of a run -> all outputs 0 asynchronously; IDLE;
//    a new start gives a full clean run.
//  6 Check a/b/c_in sequence and hold length: each vector stable exactly
//    SETTLE_CYCLES+1 clocks, in the order listed above.

Source files
------------

// File: rtl/full_adder_checker.sv
`default_nettype none
// ============================================================================
// Module   : full_adder_checker
// Purpose  : Exhaustive 8-vector response checker for a 1-bit full adder.
// Revision : 1.0  initial release
// ============================================================================
module full_adder_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  output logic                 c_in,
  input  logic                 sum,
  input  logic                 c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 fail_valid,
  output logic [2:0]           fail_vec
);

  localparam int c_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0] c_LAST_IDX = 3'd7;

  // Walk order, each entry is {a,b,c_in}.
  localparam logic [2:0] c_VEC_TABLE [8] = '{
    3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [2:0]           r_vec_idx;
  logic [c_CNT_W-1:0]   r_settle_cnt;

  logic [2:0]           w_vec_cur;
  logic [2:0]           w_vec_next;
  logic                 w_exp_sum;
  logic                 w_exp_cout;
  logic                 w_mismatch;
  logic                 w_err_sat;
  logic [ERR_CNT_W-1:0] w_err_next;

  assign w_vec_cur  = c_VEC_TABLE[r_vec_idx];
  assign w_vec_next = c_VEC_TABLE[r_vec_idx + 3'd1];

  // Golden response is taken from the table entry, not the output flops.
  assign w_exp_sum  = w_vec_cur[2] ^ w_vec_cur[1] ^ w_vec_cur[0];
  assign w_exp_cout = (w_vec_cur[2] & w_vec_cur[1]) |
                      (w_vec_cur[2] & w_vec_cur[0]) |
                      (w_vec_cur[1] & w_vec_cur[0]);
  assign w_mismatch = (sum != w_exp_sum) || (c_out != w_exp_cout);

  assign w_err_sat  = &err_count;
  assign w_err_next = (w_mismatch && !w_err_sat) ? err_count + 1'b1 : err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_vec_idx    <= 3'd0;
      r_settle_cnt <= '0;
      a            <= 1'b0;
      b            <= 1'b0;
      c_in         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_valid   <= 1'b0;
      fail_vec     <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state          <= ST_DRIVE;
            r_vec_idx        <= 3'd0;
            r_settle_cnt     <= '0;
            {a, b, c_in}     <= c_VEC_TABLE[0];
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            fail_valid       <= 1'b0;
            fail_vec         <= 3'd0;
          end
        end

        ST_DRIVE: begin
          if (r_settle_cnt == c_SETTLE_LAST) begin
            r_state      <= ST_SAMPLE;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          err_count <= w_err_next;
          if (w_mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= w_vec_cur;
          end
          if (r_vec_idx == c_LAST_IDX) begin
            r_state      <= ST_DONE;
            {a, b, c_in} <= 3'b000;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= (w_err_next == '0);
          end else begin
            r_state      <= ST_DRIVE;
            r_vec_idx    <= r_vec_idx + 3'd1;
            {a, b, c_in} <= w_vec_next;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_full_adder_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_full_adder_checker
// Purpose  : Scoreboard bench for full_adder_checker driving a faultable adder.
// Revision : 1.0  initial release
// ============================================================================
module tb_full_adder_checker;

  localparam int SETTLE    = 4;
  localparam int HOLD      = SETTLE + 1;
  localparam int RUN_EDGES = 8 * HOLD;

  typedef struct {
    int nerr;
    int fv;
    int fvec;
    int done_edge;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a, b, c_in, sum, c_out, busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] fail_vec;
  logic       a2, b2, c2, busy2, done2, pass2, fv2;
  logic [1:0] err2;
  logic [2:0] fvec2;

  logic [7:0] sum_flip  = 8'h00;
  logic [7:0] cout_flip = 8'h00;
  logic       noise_s   = 1'b0;
  logic       noise_c   = 1'b0;
  logic [1:0] total;

  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   vec_order [8] = '{0, 4, 2, 1, 6, 5, 3, 7};
  exp_t       res_q [$];
  logic [2:0] vec_q [$];
  bit   prev_done = 1'b0;

  // Faultable adder: per-vector output flips plus glitch noise between samples.
  assign total = {1'b0, a} + {1'b0, b} + {1'b0, c_in};
  assign sum   = total[0] ^ sum_flip[{a, b, c_in}]  ^ noise_s;
  assign c_out = total[1] ^ cout_flip[{a, b, c_in}] ^ noise_c;

  full_adder_checker #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c_in(c_in), .sum(sum), .c_out(c_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );

  full_adder_checker #(.SETTLE_CYCLES(SETTLE), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a2), .b(b2), .c_in(c2), .sum(sum), .c_out(c_out),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply the faulty adder to every vector and compare to arithmetic.
  function automatic exp_t ref_model(input logic [7:0] sf, input logic [7:0] cf);
    exp_t e;
    int   v, x, gs, gc, fs, fc;
    e.nerr = 0; e.fv = 0; e.fvec = 0; e.done_edge = 0;
    for (int i = 0; i < 8; i++) begin
      v  = vec_order[i];
      x  = (v / 4) + ((v / 2) % 2) + (v % 2);
      gs = x % 2;
      gc = x / 2;
      fs = gs ^ int'(sf[v]);
      fc = gc ^ int'(cf[v]);
      if (fs != gs || fc != gc) begin
        e.nerr++;
        if (e.fv == 0) begin
          e.fv   = 1;
          e.fvec = v;
        end
      end
    end
    return e;
  endfunction

  task automatic issue_start();
    exp_t e;
    @(posedge clk);
    #1;
    start = 1'b1;
    e = ref_model(sum_flip, cout_flip);
    e.done_edge = cyc + 1 + RUN_EDGES;
    res_q.push_back(e);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < HOLD; k++) vec_q.push_back(3'(vec_order[i]));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < RUN_EDGES + 20; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      if (seen && done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic pulse_run(input bit junk);
    issue_start();
    if (junk) begin
      for (int i = 0; i < 34; i++) begin
        @(posedge clk);
        #1;
        start = ($urandom_range(3) == 0);
      end
    end else begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_abc"},   int'({a, b, c_in}), 0);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_done"},  int'(done), 0);
    check({tag, "_pass"},  int'(pass), 0);
    check({tag, "_err"},   int'(err_count), 0);
    check({tag, "_fv"},    int'(fail_valid), 0);
    check({tag, "_fvec"},  int'(fail_vec), 0);
    check({tag, "_sat"},   int'({a2, b2, c2, busy2, done2, pass2, err2, fv2, fvec2}), 0);
  endtask

  // Monitor: vector sequence, idle outputs, and result scoreboard.
  initial begin
    exp_t       e;
    logic [2:0] v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
        noise_s   = 1'b0;
        noise_c   = 1'b0;
      end else begin
        if (busy) begin
          if (vec_q.size() == 0) begin
            check("vec_extra", 1, 0);
          end else begin
            v = vec_q.pop_front();
            check("vec", int'({a, b, c_in}), int'(v));
            check("vec_sat", int'({a2, b2, c2}), int'(v));
          end
        end else begin
          check("idle_vec", int'({a, b, c_in}), 0);
        end
        if (done && !prev_done) begin
          if (res_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = res_q.pop_front();
            check("done_edge",  cyc, e.done_edge);
            check("vec_left",   vec_q.size(), 0);
            check("err_count",  int'(err_count), e.nerr);
            check("fail_valid", int'(fail_valid), e.fv);
            check("fail_vec",   int'(fail_vec), e.fvec);
            check("pass",       int'(pass), (e.nerr == 0) ? 1 : 0);
            check("sat_err",    int'(err2), (e.nerr > 3) ? 3 : e.nerr);
            check("sat_fvec",   int'({fv2, fvec2}), e.fv * 8 + e.fvec);
            check("sat_state",  int'({done2, busy2, pass2}), (e.nerr == 0) ? 5 : 4);
          end
        end
        prev_done = done;
        if (busy && (vec_q.size() % HOLD != 0)) begin
          noise_s = 1'($urandom_range(1));
          noise_c = 1'($urandom_range(1));
        end else begin
          noise_s = 1'b0;
          noise_c = 1'b0;
        end
      end
    end
  end

  initial begin
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Good adder
    sum_flip = 8'h00; cout_flip = 8'h00;
    pulse_run(1'b0);
    check("t1_pass", int'(pass), 1);
    check("t1_err",  int'(err_count), 0);

    // c_out stuck at 0: carries expected for 011,101,110,111
    cout_flip = 8'hE8;
    pulse_run(1'b0);
    check("t2_err",  int'(err_count), 4);
    check("t2_fvec", int'(fail_vec), 6);
    check("t2_pass", int'(pass), 0);

    // sum inverted everywhere
    sum_flip = 8'hFF; cout_flip = 8'h00;
    pulse_run(1'b0);
    check("t3_err",  int'(err_count), 8);
    check("t3_fvec", int'(fail_vec), 0);
    check("t3_sat",  int'(err2), 3);

    // start held through a run, then restart from DONE
    sum_flip = 8'h00; cout_flip = 8'hE8;
    issue_start();
    wait_done();
    start = 1'b0;
    check("t4_err", int'(err_count), 4);
    pulse_run(1'b0);
    check("t4_rerun_err", int'(err_count), 4);

    // Abort mid-run with reset
    issue_start();
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    res_q.delete();
    vec_q.delete();
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sum_flip = 8'h10; cout_flip = 8'h00;
    pulse_run(1'b0);

    // Random faults with spurious start pulses during busy
    for (int r = 0; r < 8; r++) begin
      sum_flip  = 8'($urandom & $urandom);
      cout_flip = 8'($urandom & $urandom);
      pulse_run(1'b1);
    end

    repeat (3) @(posedge clk);
    check("res_q_empty", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
